// File: rtl/me_pkg.sv
// Purpose: shared sizes, FSM state encoding, row-pipeline tag and search-range
//          lookup for the full-search motion-estimation engine.
package me_pkg;

  localparam int unsigned BLK       = 16;            // macroblock edge (pixels)
  localparam int unsigned WIN       = 32;            // search-window edge (pixels)
  localparam int unsigned PIX_W     = 8;             // pixel width (bits)
  localparam int unsigned SAD_W     = 16;            // candidate SAD width
  localparam int unsigned ROW_SAD_W = 12;            // 16-pixel row SAD width
  localparam int unsigned OFF_W     = 5;             // offset counter width (0..16)
  localparam int unsigned WORD_W    = 64;            // memory word width
  localparam int unsigned ROW_W     = BLK * PIX_W;   // one macroblock row (128 bits)
  localparam int unsigned WROW_W    = WIN * PIX_W;   // one window row (256 bits)
  localparam int unsigned REF_WORDS = WIN * WIN * PIX_W / WORD_W;  // 128
  localparam int unsigned CUR_WORDS = BLK * BLK * PIX_W / WORD_W;  // 32
  localparam int unsigned MAX_OFF   = WIN - BLK;     // 16

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } me_state_e;

  // Tag travelling alongside a row SAD through the register stage.
  typedef struct packed {
    logic             is_first;
    logic             is_last;
    logic [OFF_W-1:0] i;
    logic [OFF_W-1:0] j;
  } row_tag_t;

  // Lowest offset searched for a range code; the range is symmetric about 8.
  function automatic logic [OFF_W-1:0] range_lo(input logic [1:0] code);
    case (code)
      2'd0:    return OFF_W'(0);
      2'd1:    return OFF_W'(4);
      2'd2:    return OFF_W'(6);
      default: return OFF_W'(7);
    endcase
  endfunction

  function automatic logic [OFF_W-1:0] range_hi(input logic [1:0] code);
    return OFF_W'(MAX_OFF) - range_lo(code);
  endfunction

endpackage

// File: rtl/me_sad_row16.sv
// Purpose: SAD of one 16-pixel row: 16 absolute differences and an adder tree,
//          with an optional output register.
// Ports:   clk, rst_n   - clock / async active-low reset (used when REG_OUT=1)
//          i_ref, i_cur - 16 packed pixels each, pixel k in bits [8k+7:8k]
//          o_sad        - row SAD (registered when REG_OUT=1)
module me_sad_row16
  import me_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROW_W-1:0]     i_ref,
  input  logic [ROW_W-1:0]     i_cur,
  output logic [ROW_SAD_W-1:0] o_sad
);

  logic [PIX_W-1:0]     w_diff [BLK];
  logic [PIX_W:0]       w_l1   [8];
  logic [PIX_W+1:0]     w_l2   [4];
  logic [PIX_W+2:0]     w_l3   [2];
  logic [ROW_SAD_W-1:0] w_sum;

  // Per-pixel absolute difference.
  always_comb begin
    for (int k = 0; k < BLK; k++) begin
      if (i_ref[k*PIX_W +: PIX_W] > i_cur[k*PIX_W +: PIX_W])
        w_diff[k] = i_ref[k*PIX_W +: PIX_W] - i_cur[k*PIX_W +: PIX_W];
      else
        w_diff[k] = i_cur[k*PIX_W +: PIX_W] - i_ref[k*PIX_W +: PIX_W];
    end
  end

  // Balanced adder tree, each level one bit wider.
  always_comb begin
    for (int k = 0; k < 8; k++)
      w_l1[k] = (PIX_W+1)'(w_diff[2*k]) + (PIX_W+1)'(w_diff[2*k+1]);
    for (int k = 0; k < 4; k++)
      w_l2[k] = (PIX_W+2)'(w_l1[2*k]) + (PIX_W+2)'(w_l1[2*k+1]);
    for (int k = 0; k < 2; k++)
      w_l3[k] = (PIX_W+3)'(w_l2[2*k]) + (PIX_W+3)'(w_l2[2*k+1]);
    w_sum = ROW_SAD_W'(w_l3[0]) + ROW_SAD_W'(w_l3[1]);
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_sad <= '0;
        else        o_sad <= w_sum;
      end
    end else begin : g_comb
      assign o_sad = w_sum;
    end
  endgenerate

endmodule

// File: rtl/me_engine.sv
// Purpose: full-search block-matching motion estimation. Holds a 16x16 current
//          block and a 32x32 reference window; on go, scans every candidate
//          offset in range and reports the lowest-SAD offset.
// Ports:   clk, reset (async active-low); r (range code, sampled on go); go;
//          address/data/write_enable_{ref,cur} - 64-bit memory load ports;
//          clk_write, clk_read - legacy, unused;
//          m_i, m_j - best row/column offset; done - one-cycle result pulse.
module me_engine
  import me_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  r,
  input  logic        go,
  input  logic        clk_write,
  input  logic [6:0]  address_write_ref,
  input  logic [63:0] data_write_ref,
  input  logic        write_enable_ref,
  input  logic [4:0]  address_write_cur,
  input  logic [63:0] data_write_cur,
  input  logic        write_enable_cur,
  input  logic        clk_read,
  output logic [7:0]  m_i,
  output logic [7:0]  m_j,
  output logic        done
);

  logic w_unused_legacy;
  assign w_unused_legacy = clk_write ^ clk_read;

  me_state_e r_state, w_state_nxt;

  logic [WORD_W-1:0] r_ref_mem [REF_WORDS];
  logic [WORD_W-1:0] r_cur_mem [CUR_WORDS];

  logic [1:0]       r_range;
  logic [OFF_W-1:0] r_lo, r_hi, r_i, r_j;
  logic [3:0]       r_y;
  logic             w_last_row;

  logic [OFF_W-1:0]     w_ref_row_idx;
  logic [WROW_W-1:0]    w_ref_row;
  logic [ROW_W-1:0]     w_ref_sel;
  logic [ROW_W-1:0]     w_cur_row;
  logic [ROW_SAD_W-1:0] w_row_sad;

  row_tag_t         r_tag;
  logic             r_tag_vld;
  logic [SAD_W-1:0] r_acc, r_best_sad, w_sum;
  logic [OFF_W-1:0] r_best_i, r_best_j, w_best_i_nxt, w_best_j_nxt;
  logic             w_better;

  // Memory loads, accepted only while idle so a running search sees stable data.
  always_ff @(posedge clk) begin
    if (write_enable_ref && (r_state == IDLE)) r_ref_mem[address_write_ref] <= data_write_ref;
    if (write_enable_cur && (r_state == IDLE)) r_cur_mem[address_write_cur] <= data_write_cur;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_last_row = (r_state == RUN) && (r_y == 4'(BLK-1)) &&
                      (r_j == r_hi) && (r_i == r_hi);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (go) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = RUN;
      RUN:     if (w_last_row) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Scan counters: y (row within block) fastest, then j, then i.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_range <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_y     <= '0;
    end else begin
      if ((r_state == IDLE) && go) r_range <= r;
      if (r_state == LOAD) begin
        r_lo <= range_lo(r_range);
        r_hi <= range_hi(r_range);
        r_i  <= range_lo(r_range);
        r_j  <= range_lo(r_range);
        r_y  <= '0;
      end else if (r_state == RUN) begin
        r_y <= r_y + 4'd1;
        if (r_y == 4'(BLK-1)) begin
          if (r_j == r_hi) begin
            r_j <= r_lo;
            r_i <= r_i + 5'd1;
          end else begin
            r_j <= r_j + 5'd1;
          end
        end
      end
    end
  end

  // Row fetch: whole 256-bit window row, then 16 bytes starting at byte j.
  always_comb begin
    w_ref_row_idx = r_i + OFF_W'(r_y);
    w_ref_row = {r_ref_mem[{w_ref_row_idx, 2'd3}], r_ref_mem[{w_ref_row_idx, 2'd2}],
                 r_ref_mem[{w_ref_row_idx, 2'd1}], r_ref_mem[{w_ref_row_idx, 2'd0}]};
    w_ref_sel = ROW_W'(w_ref_row >> {r_j, 3'b000});
    w_cur_row = {r_cur_mem[{r_y, 1'b1}], r_cur_mem[{r_y, 1'b0}]};
  end

  me_sad_row16 #(.REG_OUT(1'b1)) u_sad (
    .clk   (clk),
    .rst_n (reset),
    .i_ref (w_ref_sel),
    .i_cur (w_cur_row),
    .o_sad (w_row_sad)
  );

  // Accumulate stage: the row SAD and its tag arrive one cycle after issue.
  always_comb begin
    w_sum        = (r_tag.is_first ? '0 : r_acc) + SAD_W'(w_row_sad);
    w_better     = r_tag_vld && r_tag.is_last && (w_sum < r_best_sad);
    w_best_i_nxt = w_better ? r_tag.i : r_best_i;
    w_best_j_nxt = w_better ? r_tag.j : r_best_j;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld  <= 1'b0;
      r_tag      <= '0;
      r_acc      <= '0;
      r_best_sad <= '1;
      r_best_i   <= '0;
      r_best_j   <= '0;
      m_i        <= '0;
      m_j        <= '0;
      done       <= 1'b0;
    end else begin
      r_tag_vld <= (r_state == RUN);
      r_tag     <= '{is_first: (r_y == 4'd0), is_last: (r_y == 4'(BLK-1)), i: r_i, j: r_j};
      if (r_tag_vld && !r_tag.is_last) r_acc <= w_sum;
      // Strict less-than keeps the first offset in scan order on ties.
      if (r_state == LOAD) begin
        r_best_sad <= '1;
      end else if (w_better) begin
        r_best_sad <= w_sum;
        r_best_i   <= r_tag.i;
        r_best_j   <= r_tag.j;
      end
      // FINISH is the cycle the last candidate's final row is accumulated.
      done <= (r_state == FINISH);
      if (r_state == FINISH) begin
        m_i <= 8'(w_best_i_nxt);
        m_j <= 8'(w_best_j_nxt);
      end
    end
  end

endmodule

// File: tb/tb_me_engine.sv
// Purpose: scoreboard bench for me_engine. Stimulus pushes the expected
//          (m_i, m_j) for each search; a monitor pops and compares on done,
//          checks done is one cycle wide and that m_i/m_j hold between dones.
module tb_me_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  r;
  logic        go;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [7:0]  m_i, m_j;
  logic        done;

  always #5 clk = ~clk;

  me_engine dut (
    .clk               (clk),
    .reset             (reset),
    .r                 (r),
    .go                (go),
    .clk_write         (clk),
    .address_write_ref (address_write_ref),
    .data_write_ref    (data_write_ref),
    .write_enable_ref  (write_enable_ref),
    .address_write_cur (address_write_cur),
    .data_write_cur    (data_write_cur),
    .write_enable_cur  (write_enable_cur),
    .clk_read          (clk),
    .m_i               (m_i),
    .m_j               (m_j),
    .done              (done)
  );

  logic [7:0]  ref_px [32][32];
  logic [7:0]  cur_px [16][16];
  logic [15:0] exp_q [$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [7:0]  last_i = 8'd0;
  logic [7:0]  last_j = 8'd0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares results on done, and holds between dones.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset) begin
      last_i    = 8'd0;
      last_j    = 8'd0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", int'(done), 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("m_i", int'(m_i), int'(e[15:8]));
          check("m_j", int'(m_j), int'(e[7:0]));
        end
        last_i = m_i;
        last_j = m_j;
      end else begin
        check("hold_m_i", int'(m_i), int'(last_i));
        check("hold_m_j", int'(m_j), int'(last_j));
      end
      prev_done = done;
    end
  end

  task automatic fill_ref(input logic [7:0] v);
    for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) ref_px[y][x] = v;
  endtask

  task automatic fill_cur(input logic [7:0] v);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) cur_px[y][x] = v;
  endtask

  // Random pixels never equal 0xFF, so an 0xFF background cannot match.
  task automatic fill_cur_rand();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) cur_px[y][x] = 8'($urandom_range(0, 254));
  endtask

  task automatic embed(input int a, input int b);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) ref_px[a+y][b+x] = cur_px[y][x];
  endtask

  // Both ports write together; ref takes 128 cycles, cur the first 32.
  task automatic load_mems();
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      write_enable_ref  = 1'b1;
      address_write_ref = 7'(a);
      for (int k = 0; k < 8; k++) data_write_ref[k*8 +: 8] = ref_px[a/4][(a%4)*8 + k];
      if (a < 32) begin
        write_enable_cur  = 1'b1;
        address_write_cur = 5'(a);
        for (int k = 0; k < 8; k++) data_write_cur[k*8 +: 8] = cur_px[a/2][(a%2)*8 + k];
      end else begin
        write_enable_cur = 1'b0;
      end
    end
    @(negedge clk);
    write_enable_ref = 1'b0;
    write_enable_cur = 1'b0;
  endtask

  // Push expectation, pulse go, wait for done within 16*P+8 cycles.
  task automatic run_search(input logic [1:0] rr, input int ei, input int ej, input int ncand);
    int cnt;
    bit seen;
    exp_q.push_back({8'(ei), 8'(ej)});
    @(negedge clk);
    r  = rr;
    go = 1'b1;
    @(negedge clk);
    go   = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 16*ncand + 8) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1'b1;
    end
    check("latency_within_bound", int'(seen), 1);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; r = 2'd0; go = 1'b0;
    write_enable_ref = 1'b0; write_enable_cur = 1'b0;
    address_write_ref = '0; address_write_cur = '0;
    data_write_ref = '0; data_write_cur = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_m_i", int'(m_i), 0);
    check("reset_m_j", int'(m_j), 0);
    check("reset_done", int'(done), 0);

    // Exact match in an 0xFF background.
    fill_ref(8'hFF); fill_cur_rand(); embed(5, 11); load_mems();
    run_search(2'd0, 5, 11, 289);

    // All SADs zero: first candidate wins.
    fill_ref(8'h00); fill_cur(8'h00); load_mems();
    run_search(2'd0, 0, 0, 289);

    // Uniform equal data, r=1: first in-range candidate wins.
    fill_ref(8'h10); fill_cur(8'h10); load_mems();
    run_search(2'd1, 4, 4, 81);

    // Zero block at (2,2) out of range for r=1; (4,4) has the largest overlap.
    fill_ref(8'hFF); fill_cur(8'h00); embed(2, 2); load_mems();
    run_search(2'd1, 4, 4, 81);

    // Narrow ranges.
    fill_ref(8'hFF); fill_cur_rand(); embed(7, 9); load_mems();
    run_search(2'd3, 7, 9, 9);
    fill_ref(8'hFF); fill_cur_rand(); embed(6, 10); load_mems();
    run_search(2'd2, 6, 10, 25);

    // Window corners and word-boundary byte selection.
    fill_ref(8'hFF); fill_cur_rand(); embed(16, 16); load_mems();
    run_search(2'd0, 16, 16, 289);
    fill_ref(8'hFF); fill_cur_rand(); embed(0, 9); load_mems();
    run_search(2'd0, 0, 9, 289);

    // go and writes during RUN must be ignored; accepted writes would make
    // an all-0xFF block that matches near (0,0).
    fill_ref(8'hFF); fill_cur_rand(); embed(16, 16); load_mems();
    fork
      run_search(2'd0, 16, 16, 289);
      begin
        repeat (40) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int a = 0; a < 64; a++) begin
          @(negedge clk);
          write_enable_ref  = 1'b1;
          address_write_ref = 7'(64 + a);
          data_write_ref    = '1;
          write_enable_cur  = (a < 32);
          address_write_cur = 5'(a);
          data_write_cur    = '1;
        end
        @(negedge clk);
        write_enable_ref = 1'b0;
        write_enable_cur = 1'b0;
      end
    join

    // Reset mid-search aborts without a result.
    fill_ref(8'hFF); fill_cur_rand(); embed(10, 6); load_mems();
    @(negedge clk); r = 2'd0; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_m_i", int'(m_i), 0);
    check("abort_m_j", int'(m_j), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (16*289 + 8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no_done_after_abort", cnt, 0);
    load_mems();
    run_search(2'd0, 10, 6, 289);

    // Back-to-back blocks.
    fill_ref(8'hFF); fill_cur_rand(); embed(3, 14); load_mems();
    run_search(2'd0, 3, 14, 289);
    fill_ref(8'hFF); fill_cur_rand(); embed(9, 1); load_mems();
    run_search(2'd0, 9, 1, 289);
    fill_ref(8'hFF); fill_cur_rand(); embed(13, 8); load_mems();
    run_search(2'd0, 13, 8, 289);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/me_engine.md
Name: me_engine

Overview:
- Full-search block-matching motion-estimation engine.
- Holds one 16x16 current macroblock and one 32x32 reference search window in internal memories, both loaded through 64-bit write ports.
- On `go`, it computes SAD (sum of absolute differences) for every candidate offset and reports the best-match offset (m_i = row, m_j = column).
- Sits between the frame-buffer loader and the encoder's motion-vector stage.

Parameters:
- BLK, 16, macroblock edge in pixels.
- WIN, 32, search-window edge in pixels.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  sole clock; every register and memory is clocked by clk.
- reset  in  1  asynchronous, active-low reset.
- r  in  2  search-range code, sampled on go.
- go  in  1  one-cycle start pulse.
- clk_write  in  1  legacy port, tied to clk at integration; internally unused.
- address_write_ref  in  7  reference word address = row*4 + col/8.
- data_write_ref  in  64  8 reference pixels; byte k = pixel (col+k), byte 0 in bits [7:0].
- write_enable_ref  in  1  reference write strobe.
- address_write_cur  in  5  current word address = row*2 + col/8.
- data_write_cur  in  64  8 current pixels, same byte order as the reference port.
- write_enable_cur  in  1  current write strobe.
- clk_read  in  1  legacy port, tied to clk; internally unused.
- m_i  out  8  best row offset, unsigned, 0..16.
- m_j  out  8  best column offset, unsigned, 0..16.
- done  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (reset=0): m_i=0, m_j=0, done=0, FSM in IDLE, any search in progress aborted. Memory contents are not reset.
- Writes: synchronous on posedge clk while the enable is high. Both ports may write in the same cycle.
- Writes arriving while the FSM is not IDLE are dropped.
- Candidate offset (i,j): ref pixel (i+y, j+x) is compared with cur pixel (y, x), for y,x in 0..15.
- Candidate SAD = sum of |ref - cur| over the 256 pixels. SAD is 16 bits unsigned (max 65280); no saturation is needed.
- Search range from r, centred at offset 8:
  - r=0: offsets 0..16.
  - r=1: offsets 4..12.
  - r=2: offsets 6..10.
  - r=3: offsets 7..9.
  - Range bounds apply to both i and j.
- Scan order: i outer, j inner, both ascending.
- Best is updated only on strictly smaller SAD, so on a tie the first offset in scan order wins.
- FSM states:
  - IDLE: go=1 leads to LOAD; go is ignored in every other state.
  - LOAD: latch the range and init best SAD = 0xFFFF, then go to RUN.
  - RUN: one 16-pixel row per cycle, so 16 cycles per candidate, with a pipelined accumulator. After the last candidate, go to FINISH.
  - FINISH: register m_i/m_j, pulse done for exactly 1 cycle, return to IDLE.
- Latency: done is asserted at most 16*P + 8 cycles after the go edge, where P = candidate count (289 for r=0).
- m_i/m_j hold their value from the done cycle until the next done; they are unchanged while a new search runs.
- Row fetch: read a full 256-bit reference row (4 words), then select the 16 bytes starting at byte j. This must be correct for any j in 0..16, including word-boundary crossings.

Decomposition:
- Package me_pkg: BLK, WIN, PIX_W, SAD_W=16, the range lookup for r, and the FSM state enum (IDLE, LOAD, RUN, FINISH).
- Sub-module me_sad_row16: 16 absolute differences plus an adder tree, producing a 12-bit row SAD. It is combinational, with one optional register stage.

Test Plan:
- Exact match: ref = 0xFF everywhere except the current block (random data) embedded at offset (5,11), r=0 -> done pulse, m_i=5, m_j=11.
- All-zero cur and ref, r=0 -> every SAD is 0, so m_i=0, m_j=0 (first-in-order tie rule).
- Uniform cur=ref=0x10, r=1 -> m_i=4, m_j=4. Then exact match at (2,2) with r=1 -> result stays inside 4..12, with no out-of-range answer.
- Exact match at (16,16) and at (0,9), r=0 -> m_i/m_j = 16/16 and 0/9. This checks byte selection across word boundaries.
- Pulse go during RUN and write both memories during RUN -> no restart, writes dropped, result equals the undisturbed search.
- Assert reset mid-search -> done stays 0, m_i=m_j=0. Then a fresh load plus go gives the correct answer.
- Three back-to-back blocks (load cur+ref, go, wait done) -> each done is exactly 1 cycle wide, and m_i/m_j are stable until the next done.
